// File: rtl/banked_capture_buffer.sv
// Banked capture memory: NUM_BANKS x 2^BANK_AW words behind one flat address space,
// with auto-incrementing fill/ring write pointer and a latency-1 read port.
// Optional stored parity lane and RD_ERR: define BANKED_CAPTURE_BUFFER_PARITY_EN.
module banked_capture_buffer #(
  parameter int DATA_W    = 9,
  parameter int BANK_AW   = 11,
  parameter int NUM_BANKS = 5,
  parameter int ADDR_W    = 14
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CLEAR,
  input  logic              RING_MODE,
  input  logic              WR_VALID,
  input  logic [DATA_W-1:0] WR_DATA,
  output logic [ADDR_W-1:0] WR_PTR,
  output logic              FULL,
  output logic              WRAPPED,
  output logic              OVERFLOW,
  input  logic              RD_REQ,
  input  logic [ADDR_W-1:0] RD_ADDR,
  output logic              RD_VALID,
  output logic [DATA_W-1:0] RD_DATA,
  output logic              RD_ERR
);

  localparam int          BANK_DEPTH = 1 << BANK_AW;
  localparam int unsigned TOTAL      = NUM_BANKS * BANK_DEPTH;
  localparam int          BSEL_W     = ADDR_W - BANK_AW;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
`ifdef BANKED_CAPTURE_BUFFER_PARITY_EN
  localparam int          MEM_W      = DATA_W + 1;
`else
  localparam int          MEM_W      = DATA_W;
`endif

  if (NUM_BANKS < 1 || NUM_BANKS > 16) begin : g_chk_banks
    $error("banked_capture_buffer: NUM_BANKS must be 1..16");
  end
  if (BSEL_W < 1) begin : g_chk_bsel
    $error("banked_capture_buffer: ADDR_W must exceed BANK_AW");
  end
  if (longint'(TOTAL) > (longint'(1) << ADDR_W)) begin : g_chk_addr
    $error("banked_capture_buffer: NUM_BANKS*2^BANK_AW does not fit in ADDR_W");
  end

`ifdef BANKED_CAPTURE_BUFFER_PARITY_EN
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
`endif

  // ---- write side: pointer, flags and bank decode of WR_PTR ----
  logic              wr_en;
  logic [BSEL_W-1:0] wr_bank;
  logic [BANK_AW-1:0] wr_off;
  logic [MEM_W-1:0]  wr_word;

  assign wr_en   = WR_VALID && !FULL && !CLEAR;
  assign wr_bank = WR_PTR[ADDR_W-1:BANK_AW];
  assign wr_off  = WR_PTR[BANK_AW-1:0];
`ifdef BANKED_CAPTURE_BUFFER_PARITY_EN
  assign wr_word = {even_parity(WR_DATA), WR_DATA};
`else
  assign wr_word = WR_DATA;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      WR_PTR   <= '0;
      FULL     <= 1'b0;
      WRAPPED  <= 1'b0;
      OVERFLOW <= 1'b0;
    end else if (CLEAR) begin
      WR_PTR   <= '0;
      FULL     <= 1'b0;
      WRAPPED  <= 1'b0;
      OVERFLOW <= 1'b0;
    end else if (WR_VALID) begin
      if (FULL) begin
        OVERFLOW <= 1'b1;
      end else if (WR_PTR == LAST_ADDR) begin
        // Fill mode parks the pointer on the last word; FULL then freezes the mode.
        if (RING_MODE) begin
          WR_PTR  <= '0;
          WRAPPED <= 1'b1;
        end else begin
          FULL    <= 1'b1;
        end
      end else begin
        WR_PTR <= WR_PTR + ADDR_W'(1);
      end
    end
  end

  // ---- read stage p0: request decode ----
  logic [BSEL_W-1:0]  rd_bank_p0;
  logic [BANK_AW-1:0] rd_off_p0;
  logic               rd_in_range_p0;
  logic               rd_en_p0;

  assign rd_bank_p0     = RD_ADDR[ADDR_W-1:BANK_AW];
  assign rd_off_p0      = RD_ADDR[BANK_AW-1:0];
  assign rd_in_range_p0 = (32'(RD_ADDR) < TOTAL);
  assign rd_en_p0       = RD_REQ && rd_in_range_p0;

  // ---- RAM banks: read-first, only the addressed bank is enabled ----
  logic [MEM_W-1:0] bank_q_p1 [NUM_BANKS];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : gen_bank
    logic [MEM_W-1:0] mem [BANK_DEPTH];

    always_ff @(posedge CLK) begin
      if (wr_en && wr_bank == BSEL_W'(b))
        mem[wr_off] <= wr_word;
      if (rd_en_p0 && rd_bank_p0 == BSEL_W'(b))
        bank_q_p1[b] <= mem[rd_off_p0];
    end
  end

  // ---- read stage p1: registered select, valid and range flag ----
  logic              vld_p1;
  logic              oor_p1;
  logic [BSEL_W-1:0] bank_sel_p1;
  logic [DATA_W-1:0] rd_data_p2;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      vld_p1      <= 1'b0;
      oor_p1      <= 1'b0;
      bank_sel_p1 <= '0;
      rd_data_p2  <= '0;
    end else if (CLEAR) begin
      vld_p1      <= 1'b0;
      oor_p1      <= 1'b0;
      bank_sel_p1 <= '0;
      rd_data_p2  <= '0;
    end else begin
      vld_p1     <= RD_REQ;
      rd_data_p2 <= RD_DATA;
      if (RD_REQ) begin
        oor_p1      <= !rd_in_range_p0;
        bank_sel_p1 <= rd_bank_p0;
      end
    end
  end

  logic [MEM_W-1:0] rd_word_p1;

  always_comb begin
    rd_word_p1 = '0;
    for (int b = 0; b < NUM_BANKS; b++)
      if (bank_sel_p1 == BSEL_W'(b))
        rd_word_p1 = bank_q_p1[b];
  end

  // ---- output: RD_DATA holds its last value between requests ----
  assign RD_VALID = vld_p1;
  assign RD_DATA  = vld_p1 ? (oor_p1 ? '0 : rd_word_p1[DATA_W-1:0]) : rd_data_p2;

`ifdef BANKED_CAPTURE_BUFFER_PARITY_EN
  assign RD_ERR = vld_p1 && !oor_p1 &&
                  (even_parity(rd_word_p1[DATA_W-1:0]) != rd_word_p1[DATA_W]);
`else
  assign RD_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_banked_capture_buffer.sv
// Self-checking bench for banked_capture_buffer: directed scenarios plus a random
// phase, all checked every cycle against an array/flag model of the buffer.
module tb_banked_capture_buffer;
  localparam int DATA_W    = 9;
  localparam int BANK_AW   = 11;
  localparam int NUM_BANKS = 5;
  localparam int ADDR_W    = 14;
  localparam int TOTAL     = NUM_BANKS * (1 << BANK_AW);

  logic              CLK = 1'b0;
  logic              RESET, CLEAR, RING_MODE, WR_VALID, RD_REQ;
  logic [DATA_W-1:0] WR_DATA;
  logic [ADDR_W-1:0] RD_ADDR, WR_PTR;
  logic              FULL, WRAPPED, OVERFLOW, RD_VALID, RD_ERR;
  logic [DATA_W-1:0] RD_DATA;

  banked_capture_buffer #(
    .DATA_W(DATA_W), .BANK_AW(BANK_AW), .NUM_BANKS(NUM_BANKS), .ADDR_W(ADDR_W)
  ) dut (
    .CLK(CLK), .RESET(RESET), .CLEAR(CLEAR), .RING_MODE(RING_MODE),
    .WR_VALID(WR_VALID), .WR_DATA(WR_DATA), .WR_PTR(WR_PTR), .FULL(FULL),
    .WRAPPED(WRAPPED), .OVERFLOW(OVERFLOW), .RD_REQ(RD_REQ), .RD_ADDR(RD_ADDR),
    .RD_VALID(RD_VALID), .RD_DATA(RD_DATA), .RD_ERR(RD_ERR)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: memory image, pointer and flags as plain variables.
  int unsigned m_mem [TOTAL];
  bit          m_bad [TOTAL];
  int unsigned m_ptr, m_rd;
  bit          m_full, m_wrap, m_ovf, m_rv, m_re;

  task automatic model_reset();
    m_ptr = 0; m_full = 0; m_wrap = 0; m_ovf = 0;
    m_rv = 0; m_rd = 0; m_re = 0;
  endtask

  task automatic check_all();
    chk("wr_ptr",   WR_PTR,   m_ptr);
    chk("full",     FULL,     m_full);
    chk("wrapped",  WRAPPED,  m_wrap);
    chk("overflow", OVERFLOW, m_ovf);
    chk("rd_valid", RD_VALID, m_rv);
    chk("rd_data",  RD_DATA,  m_rd);
    chk("rd_err",   RD_ERR,   m_re);
  endtask

  // One clock: apply inputs, advance the model by the same rules, compare.
  task automatic step(input bit clr, input bit ring, input bit wv,
                      input int unsigned wd, input bit rq, input int unsigned ra);
    CLEAR = clr; RING_MODE = ring; WR_VALID = wv; WR_DATA = DATA_W'(wd);
    RD_REQ = rq; RD_ADDR = ADDR_W'(ra);
    @(posedge CLK); #1;
    if (clr) begin
      model_reset();
    end else begin
      if (rq) begin
        m_rv = 1;
        m_rd = (ra >= TOTAL) ? 0 : m_mem[ra];
`ifdef BANKED_CAPTURE_BUFFER_PARITY_EN
        m_re = (ra >= TOTAL) ? 0 : m_bad[ra];
`else
        m_re = 0;
`endif
      end else begin
        m_rv = 0;
        m_re = 0;
      end
      if (wv) begin
        if (m_full) m_ovf = 1;
        else begin
          m_mem[m_ptr] = wd % 512;
          m_bad[m_ptr] = 0;
          if (m_ptr == TOTAL - 1) begin
            if (ring) begin m_ptr = 0; m_wrap = 1; end
            else m_full = 1;
          end else m_ptr++;
        end
      end
    end
    check_all();
  endtask

  task automatic rd_chk(input string tag, input bit ring, input int unsigned a,
                        input int unsigned exp);
    step(0, ring, 0, 0, 1, a);
    chk({tag, "_vld"}, RD_VALID, 1);
    chk({tag, "_dat"}, RD_DATA, exp);
  endtask

  initial begin
    RESET = 1; CLEAR = 0; RING_MODE = 0; WR_VALID = 0; WR_DATA = '0;
    RD_REQ = 0; RD_ADDR = '0;
    for (int i = 0; i < TOTAL; i++) begin m_mem[i] = 0; m_bad[i] = 0; end
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check_all();
    chk("rst_ptr", WR_PTR, 0);
    chk("rst_rv",  RD_VALID, 0);
    RESET = 0;

    // Fill mode: value = addr mod 512.
    for (int k = 0; k < TOTAL; k++) step(0, 0, 1, k % 512, 0, 0);
    chk("fill_full", FULL, 1);
    chk("fill_ptr",  WR_PTR, TOTAL - 1);
    chk("fill_wrap", WRAPPED, 0);
    rd_chk("rd0",     0, 0,     'h000);
    rd_chk("rd2047",  0, 2047,  'h1FF);
    rd_chk("rd2048",  0, 2048,  'h000);
    rd_chk("rd8191",  0, 8191,  'h1FF);
    rd_chk("rd10239", 0, 10239, 'h1FF);

    // Write while full, then a mode flip while full.
    step(0, 0, 1, 'h155, 0, 0);
    chk("ovf_set", OVERFLOW, 1);
    rd_chk("ovf_rd", 0, 10239, 'h1FF);
    step(0, 1, 1, 'h055, 0, 0);
    chk("mode_full", FULL, 1);
    chk("mode_ptr",  WR_PTR, TOTAL - 1);
    step(1, 0, 0, 0, 0, 0);
    chk("clr_full", FULL, 0);
    chk("clr_ovf",  OVERFLOW, 0);
    chk("clr_ptr",  WR_PTR, 0);

    // Ring mode: TOTAL+5 words.
    for (int k = 0; k < TOTAL + 5; k++) step(0, 1, 1, k % 512, 0, 0);
    chk("ring_wrap", WRAPPED, 1);
    chk("ring_ptr",  WR_PTR, 5);
    rd_chk("ring_rd3", 1, 3, 'h003);
    rd_chk("ring_rd6", 1, 6, 'h006);

    // Back-to-back reads across bank boundaries, then out of range.
    rd_chk("b2b_2047", 1, 2047, 'h1FF);
    rd_chk("b2b_2048", 1, 2048, 'h000);
    rd_chk("b2b_4096", 1, 4096, 'h000);
    rd_chk("oor_12000", 1, 12000, 'h000);
    step(0, 1, 0, 0, 0, 0);
    chk("idle_vld", RD_VALID, 0);

    // Same-cycle read/write at address 100 returns old data.
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 100; k++) step(0, 0, 1, k, 0, 0);
    chk("rw_ptr", WR_PTR, 100);
    step(0, 0, 1, 'h0AA, 1, 100);
    chk("rw_old", RD_DATA, 'h064);
    rd_chk("rw_new", 0, 100, 'h0AA);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      bit clr, ring, wv, rq;
      int unsigned a;
      clr  = ($urandom_range(0, 199) == 0);
      ring = ($urandom_range(0, 63) != 0) ? RING_MODE : bit'($urandom_range(0, 1));
      wv   = $urandom_range(0, 1);
      rq   = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0)
        a = TOTAL + $urandom_range(0, (1 << ADDR_W) - TOTAL - 1);
      else
        a = $urandom_range(0, TOTAL - 1);
      step(clr, ring, wv, $urandom_range(0, 511), rq, a);
    end

`ifdef BANKED_CAPTURE_BUFFER_PARITY_EN
    dut.gen_bank[0].mem[7][DATA_W] = ~dut.gen_bank[0].mem[7][DATA_W];
    m_bad[7] = 1;
    step(0, 0, 0, 0, 1, 7);
    chk("par_err7", RD_ERR, 1);
    step(0, 0, 0, 0, 1, 8);
    chk("par_ok8", RD_ERR, 0);
`endif

    // Reset asserted during an active read.
    CLEAR = 0; WR_VALID = 0; RD_REQ = 1; RD_ADDR = ADDR_W'(5);
    @(posedge CLK); #1;
    chk("rmr_vld_pre", RD_VALID, 1);
    RESET = 1;
    #1;
    chk("rmr_vld_async", RD_VALID, 0);
    chk("rmr_dat_async", RD_DATA, 0);
    @(posedge CLK); #1;
    chk("rmr_vld_next", RD_VALID, 0);
    RD_REQ = 0;
    RESET = 0;
    model_reset();
    step(0, 0, 0, 0, 0, 0);
    rd_chk("post_rst", 0, 5, m_mem[5]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
